// File: rtl/mp_ecc_mem_ctrl_pkg.sv
// SECDED helpers, decode result type and injection modes shared by the ECC memory controller.
// Codeword layout: bit 0 = overall parity, bits 1..N = Hamming positions (powers of two are check bits).
package mem_ctrl_pkg;

  localparam int unsigned MAX_DW = 64;

  // Smallest P with 2^P >= dw + P + 1.
  function automatic int unsigned check_bits(input int unsigned dw);
    int unsigned p;
    p = 0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (p == 0 && (32'd1 << k) >= dw + k + 1) p = k;
    end
    return p;
  endfunction

  localparam int unsigned MAX_P    = check_bits(MAX_DW);
  localparam int unsigned MAX_CW   = MAX_DW + MAX_P + 1;
  localparam int unsigned CW_IW    = $clog2(MAX_CW);
  localparam int unsigned DW_IW    = $clog2(MAX_DW);
  localparam int unsigned DEF_DW   = 32;
  localparam int unsigned CW_WIDTH = DEF_DW + check_bits(DEF_DW) + 1;

  typedef logic [MAX_DW-1:0] word_t;
  typedef logic [MAX_CW-1:0] cw_t;

  typedef struct packed {
    word_t data;
    logic  sbe;
    logic  dbe;
  } dec_res_t;

  typedef enum logic [1:0] {
    INJ_NONE     = 2'b00,
    INJ_FLIP_B0  = 2'b01,
    INJ_FLIP_B01 = 2'b10,
    INJ_FLIP_D0  = 2'b11
  } inj_mode_e;

  function automatic cw_t secded_encode(input word_t data, input int unsigned dw);
    cw_t         cw;
    int unsigned p, n, d;
    logic        par;
    cw = '0;
    p  = check_bits(dw);
    n  = dw + p;
    d  = 0;
    for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        cw[CW_IW'(pos)] = data[DW_IW'(d)];
        d++;
      end
    end
    for (int unsigned k = 0; k < MAX_P; k++) begin
      if (k < p) begin
        par = 1'b0;
        for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
          if (pos <= n && ((pos >> k) & 32'd1) != 0) par ^= cw[CW_IW'(pos)];
        end
        cw[CW_IW'(32'd1 << k)] = par;
      end
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic dec_res_t secded_decode(input cw_t cw_in, input int unsigned dw);
    dec_res_t    res;
    cw_t         cw;
    int unsigned p, n, syn, d;
    logic        par, overall;
    p   = check_bits(dw);
    n   = dw + p;
    cw  = cw_in;
    syn = 0;
    for (int unsigned k = 0; k < MAX_P; k++) begin
      if (k < p) begin
        par = 1'b0;
        for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
          if (pos <= n && ((pos >> k) & 32'd1) != 0) par ^= cw[CW_IW'(pos)];
        end
        if (par) syn |= (32'd1 << k);
      end
    end
    overall = 1'b0;
    for (int unsigned pos = 0; pos < MAX_CW; pos++) begin
      if (pos <= n) overall ^= cw[CW_IW'(pos)];
    end
    res.sbe = 1'b0;
    res.dbe = 1'b0;
    // Odd overall parity means one flip; syndrome 0 points at the overall parity bit itself.
    if (overall) begin
      res.sbe = 1'b1;
      for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
        if (pos == syn) cw[CW_IW'(pos)] = ~cw[CW_IW'(pos)];
      end
    end else if (syn != 0) begin
      res.dbe = 1'b1;
    end
    res.data = '0;
    d = 0;
    for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        res.data[DW_IW'(d)] = cw[CW_IW'(pos)];
        d++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mp_ecc_mem_ctrl_if.sv
// Port-side request/response bundle for mp_ecc_mem_ctrl.
// i_inj_mode exists only when ERROR_INJECT_EN is defined.
interface mp_ecc_mem_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]                 i_en;
  logic [NUM_PORTS-1:0]                 i_we;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] i_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_din;
  logic [NUM_PORTS-1:0]                 o_ready;
  logic [NUM_PORTS-1:0]                 o_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] o_dout;
  logic [NUM_PORTS-1:0]                 o_sbe;
  logic [NUM_PORTS-1:0]                 o_dbe;
`ifdef ERROR_INJECT_EN
  logic [NUM_PORTS-1:0][1:0]            i_inj_mode;

  modport master (output i_en, i_we, i_addr, i_din, i_inj_mode,
                  input  o_ready, o_valid, o_dout, o_sbe, o_dbe);
  modport slave  (input  i_en, i_we, i_addr, i_din, i_inj_mode,
                  output o_ready, o_valid, o_dout, o_sbe, o_dbe);
`else
  modport master (output i_en, i_we, i_addr, i_din,
                  input  o_ready, o_valid, o_dout, o_sbe, o_dbe);
  modport slave  (input  i_en, i_we, i_addr, i_din,
                  output o_ready, o_valid, o_dout, o_sbe, o_dbe);
`endif
endinterface

// File: rtl/mp_ecc_mem_ctrl_rr_bank_arbiter.sv
// Per-bank round-robin arbiter: one combinational grant per cycle, pointer moves past the winner.
module rr_bank_arbiter #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant_c
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr, ptr_nxt;

  function automatic int unsigned wrap(input int unsigned v);
    return v % NUM_PORTS;
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    grant_c = '0;
    ptr_nxt = ptr;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      if (grant_c == '0 && req[PW'(wrap(32'(ptr) + off))]) begin
        grant_c[PW'(wrap(32'(ptr) + off))] = 1'b1;
        ptr_nxt = PW'(wrap(32'(ptr) + off + 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mp_ecc_mem_ctrl.sv
// Multi-port, banked, single-clock memory controller with SECDED ECC and per-bank round-robin arbitration.
// Define ERROR_INJECT_EN to enable write-path fault injection through i_inj_mode.
module mp_ecc_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic            i_clk,
  input logic            i_rst_n,
  mp_ecc_mem_ctrl_if.slave bus
);
  localparam int unsigned CW        = DATA_WIDTH + check_bits(DATA_WIDTH) + 1;
  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int unsigned BK_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_W     = (ADDR_WIDTH > BANK_BITS) ? ADDR_WIDTH - BANK_BITS : 1;
  localparam int unsigned DEPTH     = (32'd1 << ADDR_WIDTH) / NUM_BANKS;
  localparam int unsigned PIPE      = READ_LATENCY - 1;

  logic [BK_W-1:0]      bank_c   [NUM_PORTS];
  logic [ROW_W-1:0]     row_c    [NUM_PORTS];
  logic [NUM_PORTS-1:0] bank_req [NUM_BANKS];
  logic [NUM_PORTS-1:0] bank_gnt [NUM_BANKS];
  logic [NUM_PORTS-1:0] acc_c;
  logic [NUM_PORTS-1:0] rd_acc_c;
  cw_t                  enc_c    [NUM_PORTS];
  logic [CW-1:0]        wr_cw_c  [NUM_PORTS];
  logic [CW-1:0]        rd_cw_c  [NUM_PORTS];
  logic [NUM_PORTS-1:0] dec_vld_c;
  logic [CW-1:0]        dec_cw_c [NUM_PORTS];
  dec_res_t             dec_c    [NUM_PORTS];
  logic                 unused_c;

  logic [CW-1:0]                        mem [NUM_BANKS][DEPTH];
  logic [NUM_PORTS-1:0]                 valid_q, sbe_q, dbe_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout_q;

  // Low address bits pick the bank, the rest pick the row.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bank_c[p] = BK_W'(32'(bus.i_addr[p]) % NUM_BANKS);
      row_c[p]  = ROW_W'(32'(bus.i_addr[p]) >> BANK_BITS);
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++)
        bank_req[b][p] = bus.i_en[p] && (32'(bank_c[p]) == b);
    end
  end

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    rr_bank_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .req     (bank_req[b]),
      .grant_c (bank_gnt[b])
    );
  end

  always_comb begin
    acc_c = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) acc_c = acc_c | bank_gnt[b];
  end

  assign rd_acc_c    = acc_c & ~bus.i_we;
  assign bus.o_ready = ~bus.i_en | acc_c;

  // Write-path encode, with optional fault injection (codeword position 3 holds data bit 0).
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      enc_c[p] = secded_encode(word_t'(bus.i_din[p]), DATA_WIDTH);
`ifdef ERROR_INJECT_EN
      case (bus.i_inj_mode[p])
        INJ_FLIP_B0:  enc_c[p][0]   = ~enc_c[p][0];
        INJ_FLIP_B01: enc_c[p][1:0] = ~enc_c[p][1:0];
        INJ_FLIP_D0:  enc_c[p][3]   = ~enc_c[p][3];
        default:      ;
      endcase
`endif
      wr_cw_c[p] = CW'(enc_c[p]);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (acc_c[p] && bus.i_we[p]) mem[bank_c[p]][row_c[p]] <= wr_cw_c[p];
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) rd_cw_c[p] = mem[bank_c[p]][row_c[p]];
  end

  // READ_LATENCY-1 pipeline stages sit between the array read and the registered decode output.
  if (PIPE == 0) begin : g_nopipe
    always_comb begin
      dec_vld_c = rd_acc_c;
      dec_cw_c  = rd_cw_c;
    end
  end else begin : g_pipe
    logic [NUM_PORTS-1:0] vld_q [PIPE];
    logic [CW-1:0]        cw_q  [PIPE][NUM_PORTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned s = 0; s < PIPE; s++) begin
          vld_q[s] <= '0;
          for (int unsigned p = 0; p < NUM_PORTS; p++) cw_q[s][p] <= '0;
        end
      end else begin
        vld_q[0] <= rd_acc_c;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
          if (rd_acc_c[p]) cw_q[0][p] <= rd_cw_c[p];
        for (int unsigned s = 1; s < PIPE; s++) begin
          vld_q[s] <= vld_q[s-1];
          for (int unsigned p = 0; p < NUM_PORTS; p++)
            if (vld_q[s-1][p]) cw_q[s][p] <= cw_q[s-1][p];
        end
      end
    end

    always_comb begin
      dec_vld_c = vld_q[PIPE-1];
      dec_cw_c  = cw_q[PIPE-1];
    end
  end

  always_comb begin
    unused_c = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      dec_c[p] = secded_decode(cw_t'(dec_cw_c[p]), DATA_WIDTH);
      unused_c = unused_c ^ (^enc_c[p]) ^ (^dec_c[p].data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      sbe_q   <= '0;
      dbe_q   <= '0;
      dout_q  <= '0;
    end else begin
      valid_q <= dec_vld_c;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        sbe_q[p] <= dec_vld_c[p] & dec_c[p].sbe;
        dbe_q[p] <= dec_vld_c[p] & dec_c[p].dbe;
        if (dec_vld_c[p]) dout_q[p] <= DATA_WIDTH'(dec_c[p].data);
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_sbe   = sbe_q;
  assign bus.o_dbe   = dbe_q;
  assign bus.o_dout  = dout_q;

endmodule

// File: tb/tb_mp_ecc_mem_ctrl.sv
// Directed self-checking bench for mp_ecc_mem_ctrl (2 ports, 4 banks, READ_LATENCY 2).
// Injection scenarios run only when ERROR_INJECT_EN is defined.
module tb_mp_ecc_mem_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned NP = 2;
  localparam int unsigned NB = 4;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mp_ecc_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();

  mp_ecc_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .NUM_BANKS(NB), .READ_LATENCY(RL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic idle();
    bus.i_en   = '0;
    bus.i_we   = '0;
    bus.i_addr = '0;
    bus.i_din  = '0;
`ifdef ERROR_INJECT_EN
    bus.i_inj_mode = '0;
`endif
  endtask

  // Drives one request on port p and returns #1 after the accepting edge.
  task automatic do_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    bus.i_en[p] = 1'b1; bus.i_we[p] = we; bus.i_addr[p] = a; bus.i_din[p] = d;
    n = 0;
    #1;
    while (bus.o_ready[p] !== 1'b1 && n < 16) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 16) begin
      checks++; errors++;
      $display("FAIL accept_timeout port %0d ready=%b want 1", p, bus.o_ready[p]);
    end
    @(posedge clk); #1;
    bus.i_en[p] = 1'b0; bus.i_we[p] = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", bus.o_valid); end
    checks++; if (bus.o_dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.o_dout); end
    checks++; if ({bus.o_sbe, bus.o_dbe} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.o_sbe, bus.o_dbe}); end
    checks++; if (bus.o_ready !== 2'b11) begin errors++; $display("FAIL reset_ready_idle got %b want 11", bus.o_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    do_req(0, 1'b1, 10'h004, 32'hDEADBEEF);
    @(negedge clk);
    bus.i_en[0] = 1'b1; bus.i_we[0] = 1'b0; bus.i_addr[0] = 10'h004;
    #1;
    checks++; if (bus.o_ready[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_ready got %b want 1", bus.o_ready[0]); end
    @(posedge clk); #1;
    bus.i_en[0] = 1'b0;
    checks++; if (bus.o_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_rd_early_valid got %b want 0", bus.o_valid[0]); end
    @(posedge clk); #1;
    checks++; if (bus.o_valid[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_valid got %b want 1", bus.o_valid[0]); end
    checks++; if (bus.o_dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h want deadbeef", bus.o_dout[0]); end
    checks++; if ({bus.o_sbe[0], bus.o_dbe[0]} !== 2'b00) begin errors++; $display("FAIL wr_rd_flags got %b want 00", {bus.o_sbe[0], bus.o_dbe[0]}); end
    @(posedge clk); #1;
    checks++; if (bus.o_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_rd_valid_once got %b want 0", bus.o_valid[0]); end
  endtask

  task automatic test_conflict();
    int   v0, v1;
    logic exp0;
    do_req(0, 1'b1, 10'h001, 32'h1111_0001);
    do_req(1, 1'b1, 10'h005, 32'h5555_0005);
    v0 = 0; v1 = 0;
    @(negedge clk);
    bus.i_en = 2'b11; bus.i_we = 2'b00;
    bus.i_addr[0] = 10'h001; bus.i_addr[1] = 10'h005;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        #1;
        exp0 = (c % 2 == 0);
        checks++; if (bus.o_ready[0] !== exp0) begin errors++; $display("FAIL conflict_ready0 cyc %0d got %b want %b", c, bus.o_ready[0], exp0); end
        checks++; if (bus.o_ready[1] !== ~exp0) begin errors++; $display("FAIL conflict_ready1 cyc %0d got %b want %b", c, bus.o_ready[1], ~exp0); end
      end
      @(posedge clk); #1;
      if (c == 3) bus.i_en = 2'b00;
      if (bus.o_valid[0] === 1'b1) begin
        v0++;
        checks++; if (bus.o_dout[0] !== 32'h1111_0001) begin errors++; $display("FAIL conflict_data0 got %h want 11110001", bus.o_dout[0]); end
      end
      if (bus.o_valid[1] === 1'b1) begin
        v1++;
        checks++; if (bus.o_dout[1] !== 32'h5555_0005) begin errors++; $display("FAIL conflict_data1 got %h want 55550005", bus.o_dout[1]); end
      end
      @(negedge clk);
    end
    checks++; if (v0 !== 2) begin errors++; $display("FAIL conflict_count0 got %0d want 2", v0); end
    checks++; if (v1 !== 2) begin errors++; $display("FAIL conflict_count1 got %0d want 2", v1); end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    bus.i_en = 2'b11; bus.i_we = 2'b11;
    bus.i_addr[0] = 10'h000; bus.i_din[0] = 32'h0BAD_F00D;
    bus.i_addr[1] = 10'h001; bus.i_din[1] = 32'hCAFE_1234;
    #1;
    checks++; if (bus.o_ready !== 2'b11) begin errors++; $display("FAIL par_wr_ready got %b want 11", bus.o_ready); end
    @(posedge clk); #1;
    bus.i_we = 2'b00;
    @(negedge clk);
    #1;
    checks++; if (bus.o_ready !== 2'b11) begin errors++; $display("FAIL par_rd_ready got %b want 11", bus.o_ready); end
    @(posedge clk); #1;
    bus.i_en = 2'b00;
    @(posedge clk); #1;
    checks++; if (bus.o_valid !== 2'b11) begin errors++; $display("FAIL par_valid got %b want 11", bus.o_valid); end
    checks++; if (bus.o_dout[0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL par_data0 got %h want 0badf00d", bus.o_dout[0]); end
    checks++; if (bus.o_dout[1] !== 32'hCAFE_1234) begin errors++; $display("FAIL par_data1 got %h want cafe1234", bus.o_dout[1]); end
  endtask

  task automatic test_back_to_back();
    do_req(0, 1'b1, 10'h008, 32'hA5A5A5A5);
    @(negedge clk);
    bus.i_en[0] = 1'b1; bus.i_we[0] = 1'b0; bus.i_addr[0] = 10'h008;
    #1;
    checks++; if (bus.o_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_a got %b want 1", bus.o_ready[0]); end
    @(posedge clk); #1;
    @(negedge clk);
    bus.i_addr[0] = 10'h004;
    #1;
    checks++; if (bus.o_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_b got %b want 1", bus.o_ready[0]); end
    @(posedge clk); #1;
    checks++; if (bus.o_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid_a got %b want 1", bus.o_valid[0]); end
    checks++; if (bus.o_dout[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_data_a got %h want a5a5a5a5", bus.o_dout[0]); end
    @(negedge clk);
    bus.i_en[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.o_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid_b got %b want 1", bus.o_valid[0]); end
    checks++; if (bus.o_dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data_b got %h want deadbeef", bus.o_dout[0]); end
  endtask

`ifdef ERROR_INJECT_EN
  task automatic test_inject();
    logic [1:0] modes [3];
    logic [1:0] exp_flags [3];
    modes[0] = 2'b01; exp_flags[0] = 2'b10;
    modes[1] = 2'b10; exp_flags[1] = 2'b01;
    modes[2] = 2'b11; exp_flags[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      bus.i_inj_mode[0] = modes[i];
      do_req(0, 1'b1, 10'h010, 32'h12345678);
      bus.i_inj_mode[0] = 2'b00;
      do_req(0, 1'b0, 10'h010, 32'h0);
      @(posedge clk); #1;
      checks++; if (bus.o_valid[0] !== 1'b1) begin errors++; $display("FAIL inj_valid mode %b got %b want 1", modes[i], bus.o_valid[0]); end
      checks++; if (bus.o_dout[0] !== 32'h12345678) begin errors++; $display("FAIL inj_data mode %b got %h want 12345678", modes[i], bus.o_dout[0]); end
      checks++; if ({bus.o_sbe[0], bus.o_dbe[0]} !== exp_flags[i]) begin errors++; $display("FAIL inj_flags mode %b got %b want %b", modes[i], {bus.o_sbe[0], bus.o_dbe[0]}, exp_flags[i]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_req(0, 1'b0, 10'h004, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL rstmid_valid got %b want 00", bus.o_valid); end
    checks++; if (bus.o_dout !== '0) begin errors++; $display("FAIL rstmid_dout got %h want 0", bus.o_dout); end
    checks++; if ({bus.o_sbe, bus.o_dbe} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b want 0000", {bus.o_sbe, bus.o_dbe}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.o_valid !== 2'b00) begin errors++; $display("FAIL rstmid_dropped cyc %0d got %b want 00", c, bus.o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_parallel();
    test_back_to_back();
`ifdef ERROR_INJECT_EN
    test_inject();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
